// File: rtl/mul_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one WIDTHxWIDTH multiplier
//            between NUM_REQ requesters via the start/clear/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
  output logic [NUM_REQ-1:0]       done,
  output logic [2*WIDTH-1:0]       result,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [WIDTH-1:0]         m_multiplier,
  output logic [WIDTH-1:0]         m_multiplicand,
  output logic                     m_op_start,
  output logic                     m_op_clear,
  input  logic                     m_op_done,
  input  logic [2*WIDTH-1:0]       m_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [3:0] c_num_req = 4'(NUM_REQ);
  localparam logic [2:0] c_last    = 3'(NUM_REQ - 1);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic [2*WIDTH-1:0]   r_result, w_result_nxt;
  logic [2:0]           r_grant_id, w_grant_id_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [WIDTH-1:0]     r_mcand, w_mcand_nxt;
  logic                 r_start, w_start_nxt;
  logic                 r_clear, w_clear_nxt;

  logic [2*NUM_REQ-1:0] w_req_rot;
  logic                 w_any_req;
  logic [2:0]           w_winner;
  logic [3:0]           w_sum;
  logic [WIDTH-1:0]     w_sel_a, w_sel_b;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the first
  // set bit from the bottom is the round-robin winner.
  assign w_req_rot = {req, req} >> r_rr_ptr;

  always_comb begin
    w_any_req = 1'b0;
    w_winner  = '0;
    w_sum     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_any_req = 1'b1;
        w_sum     = {1'b0, r_rr_ptr} + 4'(i);
        if (w_sum >= c_num_req) begin
          w_sum = w_sum - c_num_req;
        end
        w_winner = w_sum[2:0];
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_sel_a = req_multiplier[i*WIDTH +: WIDTH];
        w_sel_b = req_multiplicand[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_done     <= '0;
      r_result   <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_mplier   <= '0;
      r_mcand    <= '0;
      r_start    <= 1'b0;
      r_clear    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_done     <= w_done_nxt;
      r_result   <= w_result_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= w_busy_nxt;
      r_mplier   <= w_mplier_nxt;
      r_mcand    <= w_mcand_nxt;
      r_start    <= w_start_nxt;
      r_clear    <= w_clear_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_done_nxt     = '0;
    w_result_nxt   = r_result;
    w_grant_id_nxt = r_grant_id;
    w_busy_nxt     = r_busy;
    w_mplier_nxt   = r_mplier;
    w_mcand_nxt    = r_mcand;
    w_start_nxt    = r_start;
    w_clear_nxt    = r_clear;
    case (r_state)
      ST_IDLE: begin
        w_start_nxt = 1'b0;
        w_clear_nxt = 1'b0;
        if (w_any_req) begin
          w_grant_id_nxt = w_winner;
          w_mplier_nxt   = w_sel_a;
          w_mcand_nxt    = w_sel_b;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_start_nxt = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (m_op_done) begin
          w_result_nxt = m_result;
          for (int i = 0; i < NUM_REQ; i++) begin
            w_done_nxt[i] = (r_grant_id == 3'(i));
          end
          w_start_nxt = 1'b0;
          w_clear_nxt = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clear_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_rr_ptr_nxt = (r_grant_id == c_last) ? 3'd0 : r_grant_id + 3'd1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign done           = r_done;
  assign result         = r_result;
  assign grant_id       = r_grant_id;
  assign busy           = r_busy;
  assign m_multiplier   = r_mplier;
  assign m_multiplicand = r_mcand;
  assign m_op_start     = r_start;
  assign m_op_clear     = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_share_arbiter
// Brief    : Self-checking bench for mul_share_arbiter with a variable-latency
//            multiplier model and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;
  localparam int N = 3;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];
  logic [N*W-1:0] req_multiplier, req_multiplicand;
  logic [N-1:0]   done;
  logic [2*W-1:0] result;
  logic [2:0]     grant_id;
  logic           busy;
  logic [W-1:0]   m_multiplier, m_multiplicand;
  logic           m_op_start, m_op_clear, m_op_done;
  logic [2*W-1:0] m_result;

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;
  int lat = 4;
  int mcnt;
  int multi_done = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_multiplier[g*W +: W]   = op_a[g];
    assign req_multiplicand[g*W +: W] = op_b[g];
  end

  mul_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .done(done), .result(result), .grant_id(grant_id), .busy(busy),
    .m_multiplier(m_multiplier), .m_multiplicand(m_multiplicand),
    .m_op_start(m_op_start), .m_op_clear(m_op_clear),
    .m_op_done(m_op_done), .m_result(m_result)
  );

  // Multiplier model: op_done rises lat cycles after op_start is seen, holds until op_clear
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= 0; m_op_done <= 1'b0; m_result <= '0;
    end else if (m_op_clear) begin
      mcnt <= 0; m_op_done <= 1'b0;
    end else if (m_op_start && !m_op_done) begin
      if (mcnt >= lat - 1) begin
        m_op_done <= 1'b1;
        m_result  <= {{W{1'b0}}, m_multiplier} * {{W{1'b0}}, m_multiplicand};
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && $countones(done) > 1) multi_done++;
    if (reset_n && (|done)) done_pulses++;
  end

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic int model_winner(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (((mask >> ((ptr + k) % N)) & N'(1)) != 0) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_done(output int idx, output logic [2*W-1:0] res, output bit to);
    to = 1'b1; idx = -1; res = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (|done) begin
        for (int i = N - 1; i >= 0; i--) if (((done >> i) & N'(1)) != 0) idx = i;
        res = result; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit to);
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_op_start) begin to = 1'b0; break; end
    end
  endtask

  task automatic serve(input bit drop, output int got, output int exp_w,
                       output logic [2*W-1:0] res);
    bit to;
    exp_w = model_winner(req, model_ptr);
    wait_done(got, res, to);
    if (!to && exp_w >= 0) model_ptr = (exp_w + 1) % N;
    if (drop && got >= 0) req = req & ~(N'(1) << got);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req = '0; lat = 4;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, grant_id, busy, m_op_start, m_op_clear} !== '0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, want 0", {done, grant_id, busy, m_op_start, m_op_clear});
    end
    n_cmp++;
    if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h, want 0", result); end
    n_cmp++;
    if ({m_multiplier, m_multiplicand} !== '0) begin
      n_err++; $display("FAIL reset_operands: got %h %h, want 0", m_multiplier, m_multiplicand);
    end
    reset_n = 1'b1; model_ptr = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b, want 0", busy); end
  endtask

  task automatic test_single;
    int first_start = -1, start_cnt = 0, done_cnt = 0, done_at = -1;
    int clear_cnt = 0, clear_at = -1, busy_cnt = 0;
    logic [2*W-1:0] res = '0;
    op_a[0] = 64'd5; op_b[0] = 64'd7; lat = 4; req = 3'b001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_op_start) begin if (first_start < 0) first_start = k; start_cnt++; end
      if (|done) begin done_cnt++; done_at = k; res = result; req = '0; end
      if (m_op_clear) begin clear_cnt++; clear_at = k; end
      if (busy) busy_cnt++;
    end
    model_ptr = 1;
    n_cmp++; if (first_start !== 1) begin n_err++; $display("FAIL single_start_at: got %0d, want 1", first_start); end
    n_cmp++; if (start_cnt !== 5) begin n_err++; $display("FAIL single_start_len: got %0d, want 5", start_cnt); end
    n_cmp++; if (done_at !== 6) begin n_err++; $display("FAIL single_latency: got %0d, want 6", done_at); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL single_done_cnt: got %0d, want 1", done_cnt); end
    n_cmp++; if (clear_at !== 6 || clear_cnt !== 1) begin
      n_err++; $display("FAIL single_clear: at %0d len %0d, want at 6 len 1", clear_at, clear_cnt);
    end
    n_cmp++; if (busy_cnt !== 7) begin n_err++; $display("FAIL single_busy_len: got %0d, want 7", busy_cnt); end
    n_cmp++; if (res !== 128'd35) begin n_err++; $display("FAIL single_result: got %0d, want 35", res); end
    n_cmp++; if (grant_id !== 3'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_final: grant %0d busy %b, want 0 0", grant_id, busy);
    end
  endtask

  task automatic test_simultaneous;
    int got0, got1, e;
    logic [2*W-1:0] r0, r1;
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; model_ptr = 0;
    multi_done = 0;
    op_a[0] = 64'd3; op_b[0] = 64'd4; op_a[1] = 64'd6; op_b[1] = 64'd9;
    lat = int'($urandom_range(1, 5)); req = 3'b011;
    serve(1'b1, got0, e, r0);
    serve(1'b1, got1, e, r1);
    n_cmp++; if (got0 !== 0 || r0 !== 128'd12) begin n_err++; $display("FAIL simul_first: id %0d res %0d, want 0 12", got0, r0); end
    n_cmp++; if (got1 !== 1 || r1 !== 128'd54) begin n_err++; $display("FAIL simul_second: id %0d res %0d, want 1 54", got1, r1); end
    n_cmp++; if (multi_done !== 0) begin n_err++; $display("FAIL simul_onehot: %0d multi-bit cycles, want 0", multi_done); end
  endtask

  task automatic test_fairness;
    int got, e;
    logic [2*W-1:0] r;
    for (int i = 0; i < 2; i++) begin op_a[i] = {$urandom, $urandom}; op_b[i] = 64'($urandom); end
    req = 3'b011;
    for (int k = 0; k < 4; k++) begin
      lat = int'($urandom_range(1, 6));
      serve(1'b0, got, e, r);
      if (k == 3) req = '0;
      n_cmp++; if (got !== (k % 2)) begin n_err++; $display("FAIL fair_grant%0d: got %0d, want %0d", k, got, k % 2); end
      n_cmp++; if (r !== prod(op_a[k % 2], op_b[k % 2])) begin
        n_err++; $display("FAIL fair_result%0d: got %h, want %h", k, r, prod(op_a[k % 2], op_b[k % 2]));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_idle: busy %b, want 0", busy); end
  endtask

  task automatic test_full_width;
    int got, e;
    logic [2*W-1:0] r;
    op_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; op_b[0] = 64'd2; lat = 3; req = 3'b001;
    serve(1'b1, got, e, r);
    n_cmp++; if (r !== {64'h1, 64'hFFFF_FFFF_FFFF_FFFE}) begin n_err++; $display("FAIL full_width: got %h", r); end
    op_a[1] = 64'd0; op_b[1] = 64'd123; req = 3'b010;
    serve(1'b1, got, e, r);
    n_cmp++; if (got !== 1 || r !== '0) begin n_err++; $display("FAIL zero_operand: id %0d res %h, want 1 0", got, r); end
  endtask

  task automatic test_reset_mid_run;
    int got, e, pulses;
    bit to;
    logic [2*W-1:0] r;
    op_a[0] = 64'd21; op_b[0] = 64'd2; op_a[2] = 64'd100; op_b[2] = 64'd3;
    lat = 8; req = 3'b101;
    wait_start(to);
    n_cmp++; if (to !== 1'b0 || grant_id !== 3'd2) begin n_err++; $display("FAIL abort_pregrant: to %b id %0d, want 0 2", to, grant_id); end
    pulses = done_pulses;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({done, grant_id, busy, m_op_start, m_op_clear, m_multiplier, m_multiplicand, result} !== '0) begin
      n_err++; $display("FAIL abort_outputs: done %b id %0d busy %b start %b clear %b", done, grant_id, busy, m_op_start, m_op_clear);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; model_ptr = 0;
    n_cmp++; if (done_pulses !== pulses) begin n_err++; $display("FAIL abort_no_done: %0d pulses, want %0d", done_pulses, pulses); end
    lat = 4;
    serve(1'b1, got, e, r);
    n_cmp++; if (got !== 0 || r !== 128'd42) begin n_err++; $display("FAIL abort_regrant: id %0d res %0d, want 0 42", got, r); end
    serve(1'b1, got, e, r);
    n_cmp++; if (got !== 2 || r !== 128'd300) begin n_err++; $display("FAIL abort_next: id %0d res %0d, want 2 300", got, r); end
  endtask

  task automatic test_late_operand;
    int got, e;
    bit to;
    logic [2*W-1:0] r;
    op_a[1] = 64'd11; op_b[1] = 64'd13; lat = 6; req = 3'b010;
    wait_start(to);
    op_b[1] = 64'd99;
    @(negedge clk);
    n_cmp++; if (m_multiplicand !== 64'd13) begin n_err++; $display("FAIL late_operand_hold: got %0d, want 13", m_multiplicand); end
    serve(1'b1, got, e, r);
    n_cmp++; if (r !== 128'd143) begin n_err++; $display("FAIL late_operand_result: got %0d, want 143", r); end
  endtask

  task automatic test_random;
    int got, e;
    logic [2*W-1:0] r, want;
    for (int i = 0; i < N; i++) begin op_a[i] = {$urandom, $urandom}; op_b[i] = {$urandom, $urandom}; end
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int it = 0; it < 40; it++) begin
      lat = int'($urandom_range(1, 6));
      serve(1'b1, got, e, r);
      want = (e >= 0) ? prod(op_a[e], op_b[e]) : '0;
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL rand_grant%0d: got %0d, want %0d", it, got, e); end
      n_cmp++; if (r !== want) begin n_err++; $display("FAIL rand_result%0d: got %h, want %h", it, r, want); end
      for (int i = 0; i < N; i++) begin
        if (((req >> i) & N'(1)) == 0 && $urandom_range(0, 9) < 4) begin
          case ($urandom_range(0, 5))
            0: op_a[i] = '0;
            1: op_a[i] = '1;
            default: op_a[i] = {$urandom, $urandom};
          endcase
          op_b[i] = {$urandom, $urandom};
          req = req | (N'(1) << i);
        end
      end
      if (req == '0) req = N'(1) << $urandom_range(0, N - 1);
    end
    req = '0;
    repeat (4) @(negedge clk);
    n_cmp++; if (multi_done !== 0) begin n_err++; $display("FAIL rand_onehot: %0d multi-bit cycles, want 0", multi_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_full_width();
    test_reset_mid_run();
    test_late_operand();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
